snow64_lar_line_scalar_writer: RTL

SNOW64_LAR_LINE_SCALAR_WRITER -- requirements
Module: snow64_lar_line_scalar_writer

---
 rtl/snow64_lar_line_scalar_writer_pkg.sv | 33 +++
 rtl/snow64_lar_line_scalar_writer_lane_merge.sv | 62 ++++++
 rtl/snow64_lar_line_scalar_writer.sv | 99 +++++++++
 3 files changed

// File: rtl/snow64_lar_line_scalar_writer_pkg.sv
// Shared types and widths for the LAR line scalar writer.
//   data_type_t : scalar data type encoding of a write request
//   int_size_t  : integer lane size encoding (8/16/32/64 bits)
//   state_t     : writer FSM states
//   LINE_W / SCALAR_W / OFFSET_W / LINE_BYTES : default datapath widths
package PkgSnow64ScalarDataShifter;

   localparam int unsigned LINE_W     = 256;
   localparam int unsigned SCALAR_W   = 64;
   localparam int unsigned OFFSET_W   = 5;
   localparam int unsigned LINE_BYTES = LINE_W / 8;

   typedef enum logic [1:0] {
      DtUnsgnInt = 2'd0,
      DtSgnInt   = 2'd1,
      DtBFloat16 = 2'd2,
      DtReserved = 2'd3
   } data_type_t;

   typedef enum logic [1:0] {
      Sz8  = 2'd0,
      Sz16 = 2'd1,
      Sz32 = 2'd2,
      Sz64 = 2'd3
   } int_size_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StHold  = 2'd1,
      StFlush = 2'd2
   } state_t;

endpackage

// File: rtl/snow64_lar_line_scalar_writer_lane_merge.sv
// Combinational lane merge: replaces one lane of a line with the low bits
// of a scalar and reports which bytes of the line that lane covers.
//   line_i      : current line contents
//   scalar_i    : scalar to insert (low lane-width bits used)
//   dtype_i     : data type (Reserved writes leave the line untouched)
//   size_i      : integer lane size (ignored for BFloat16, which is 16-bit)
//   offset_i    : byte offset; low bits below lane alignment are ignored
//   line_o      : merged line
//   byte_mask_o : bytes covered by the written lane
module snow64_scalar_lane_merge
   import PkgSnow64ScalarDataShifter::*;
#(
   parameter int unsigned LINE_WIDTH   = 256,
   parameter int unsigned SCALAR_WIDTH = 64
) (
   input  logic [LINE_WIDTH-1:0]   line_i,
   input  logic [SCALAR_WIDTH-1:0] scalar_i,
   input  data_type_t              dtype_i,
   input  int_size_t               size_i,
   input  logic [OFFSET_W-1:0]     offset_i,
   output logic [LINE_WIDTH-1:0]   line_o,
   output logic [LINE_WIDTH/8-1:0] byte_mask_o
);

   // log2 of the lane size in bytes, and the byte-within-lane mask
   logic [1:0]          shift;
   logic [2:0]          lb_mask;
   logic [OFFSET_W-1:0] lane_idx;
   logic [OFFSET_W-1:0] byte_pos;
   logic [2:0]          sel;

   always_comb begin
      shift = (dtype_i == DtBFloat16) ? 2'd1 : size_i;
      unique case (shift)
         2'd0:    lb_mask = 3'd0;
         2'd1:    lb_mask = 3'd1;
         2'd2:    lb_mask = 3'd3;
         default: lb_mask = 3'd7;
      endcase
      lane_idx = offset_i >> shift;
   end

   // Byte-granular merge: every byte whose lane index matches the target
   // lane takes the scalar byte at its position within the lane.
   always_comb begin
      line_o      = line_i;
      byte_mask_o = '0;
      byte_pos    = '0;
      sel         = '0;
      if (dtype_i != DtReserved) begin
         for (int unsigned b = 0; b < LINE_WIDTH / 8; b++) begin
            byte_pos = OFFSET_W'(b);
            if ((byte_pos >> shift) == lane_idx) begin
               sel                 = byte_pos[2:0] & lb_mask;
               line_o[8*b +: 8]    = scalar_i[8*sel +: 8];
               byte_mask_o[b]      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/snow64_lar_line_scalar_writer.sv
// LAR line scalar writer: holds a loaded line, merges scalar writes into
// it lane by lane while tracking written bytes, and emits the line on flush.
//   in_load_valid / in_load_data / out_load_ready : line load handshake (IDLE)
//   in_wr_* / out_wr_ready                         : scalar write handshake (HOLD)
//   in_flush                                       : move HOLD -> FLUSH
//   out_valid / in_out_ready / out_data / out_byte_mask : emitted line
module snow64_lar_line_scalar_writer
   import PkgSnow64ScalarDataShifter::*;
#(
   parameter int unsigned LINE_WIDTH   = 256,
   parameter int unsigned SCALAR_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_load_valid,
   input  logic [LINE_WIDTH-1:0]   in_load_data,
   output logic                    out_load_ready,
   input  logic                    in_wr_valid,
   input  logic [SCALAR_WIDTH-1:0] in_wr_data,
   input  logic [1:0]              in_wr_data_type,
   input  logic [1:0]              in_wr_int_type_size,
   input  logic [OFFSET_W-1:0]     in_wr_data_offset,
   output logic                    out_wr_ready,
   input  logic                    in_flush,
   output logic                    out_valid,
   input  logic                    in_out_ready,
   output logic [LINE_WIDTH-1:0]   out_data,
   output logic [LINE_WIDTH/8-1:0] out_byte_mask
);

   state_t                  state_q, state_d;
   logic [LINE_WIDTH-1:0]   line_q, line_d;
   logic [LINE_WIDTH/8-1:0] mask_q, mask_d;

   logic [LINE_WIDTH-1:0]   merged_line;
   logic [LINE_WIDTH/8-1:0] lane_mask;

   snow64_scalar_lane_merge #(
      .LINE_WIDTH  (LINE_WIDTH),
      .SCALAR_WIDTH(SCALAR_WIDTH)
   ) u_merge (
      .line_i     (line_q),
      .scalar_i   (in_wr_data),
      .dtype_i    (data_type_t'(in_wr_data_type)),
      .size_i     (int_size_t'(in_wr_int_type_size)),
      .offset_i   (in_wr_data_offset),
      .line_o     (merged_line),
      .byte_mask_o(lane_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         line_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      line_d         = line_q;
      mask_d         = mask_q;
      out_load_ready = 1'b0;
      out_wr_ready   = 1'b0;
      out_valid      = 1'b0;
      unique case (state_q)
         StIdle: begin
            out_load_ready = 1'b1;
            if (in_load_valid) begin
               line_d  = in_load_data;
               mask_d  = '0;
               state_d = StHold;
            end
         end
         StHold: begin
            out_wr_ready = 1'b1;
            // Reserved writes yield merged_line == line_q and an empty lane_mask.
            if (in_wr_valid) begin
               line_d = merged_line;
               mask_d = mask_q | lane_mask;
            end
            if (in_flush) state_d = StFlush;
         end
         StFlush: begin
            out_valid = 1'b1;
            if (in_out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign out_data      = line_q;
   assign out_byte_mask = mask_q;

endmodule
